// File: rtl/bch_decoder.sv
// rtl/bch_decoder.sv - BCH(63,51) t=2 serial decoder: syndromes, inversion-free Chien search, serial/parallel output
module bch_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic        data_in,
    output logic        valid_out,
    input  logic        ready_out,
    output logic        data_out,
    output logic        last_out,
    output logic [50:0] data_out_all,
    output logic [1:0]  err_cnt,
    output logic        uncorrectable
);

    typedef enum logic [1:0] {RECV, CALC, CHIEN, SEND} state_t;

    state_t      state, state_nxt;
    logic [62:0] rbuf;
    logic [50:0] flip;
    logic [50:0] out_sr;
    logic [5:0]  cnt;
    logic [5:0]  out_idx;
    logic [5:0]  s1, s3;
    logic [5:0]  l0, l1, l2;
    logic [1:0]  exp_deg, roots;
    logic        fail;

    logic [5:0]  s1_sq, s1_cube;
    logic        hit;
    logic        unc_w;
    logic [50:0] msg_w;

    // GF(64), p(x)=x^6+x+1: multiply by alpha is a shift with x^6 folded to x+1
    function automatic logic [5:0] mul_a(input logic [5:0] v);
        return {v[4:0], 1'b0} ^ {4'b0000, v[5], v[5]};
    endfunction

    function automatic logic [5:0] mul_a2(input logic [5:0] v);
        return mul_a(mul_a(v));
    endfunction

    function automatic logic [5:0] mul_a3(input logic [5:0] v);
        return mul_a(mul_a(mul_a(v)));
    endfunction

    // Squaring is linear in GF(2^m): bit i maps to alpha^(2i)
    function automatic logic [5:0] gf_sq(input logic [5:0] v);
        return ({6{v[0]}} & 6'h01) ^ ({6{v[1]}} & 6'h04) ^ ({6{v[2]}} & 6'h10)
             ^ ({6{v[3]}} & 6'h03) ^ ({6{v[4]}} & 6'h0C) ^ ({6{v[5]}} & 6'h30);
    endfunction

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        p = 6'd0;
        for (int i = 5; i >= 0; i--) begin
            p = mul_a(p) ^ (b[i] ? a : 6'd0);
        end
        return p;
    endfunction

    assign s1_sq   = gf_sq(s1);
    assign s1_cube = gf_mul(s1_sq, s1);
    assign hit     = (exp_deg != 2'd0) && ((l0 ^ l1 ^ l2) == 6'd0);
    assign unc_w   = fail || (roots != exp_deg);
    // A failed decode hands back the raw received message, so the flip mask is dropped
    assign msg_w   = rbuf[62:12] ^ (unc_w ? 51'd0 : flip);

    assign ready_in = (state == RECV);
    assign data_out = out_sr[50];
    assign last_out = valid_out && (out_idx == 6'd50);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RECV:    if (valid_in && cnt == 6'd62) state_nxt = CALC;
            CALC:    state_nxt = CHIEN;
            CHIEN:   if (cnt == 6'd62) state_nxt = SEND;
            SEND:    if (valid_out && ready_out && out_idx == 6'd50) state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 6'd0;
            s1            <= 6'd0;
            s3            <= 6'd0;
            valid_out     <= 1'b0;
            out_sr        <= 51'd0;
            out_idx       <= 6'd0;
            data_out_all  <= 51'd0;
            err_cnt       <= 2'd0;
            uncorrectable <= 1'b0;
        end else begin
            case (state)
                RECV: begin
                    if (valid_in) begin
                        rbuf <= {rbuf[61:0], data_in};
                        s1   <= mul_a(s1) ^ {5'd0, data_in};
                        s3   <= mul_a3(s3) ^ {5'd0, data_in};
                        cnt  <= (cnt == 6'd62) ? 6'd0 : cnt + 6'd1;
                    end
                end
                CALC: begin
                    // Locator S1 + S1^2 x + (S3+S1^3) x^2, pre-stepped to x = alpha^-62
                    l0    <= s1;
                    l1    <= mul_a(s1_sq);
                    l2    <= mul_a2(s3 ^ s1_cube);
                    roots <= 2'd0;
                    flip  <= 51'd0;
                    fail  <= (s1 == 6'd0) && (s3 != 6'd0);
                    if (s1 == 6'd0)
                        exp_deg <= 2'd0;
                    else if (s3 == s1_cube)
                        exp_deg <= 2'd1;
                    else
                        exp_deg <= 2'd2;
                    s1 <= 6'd0;
                    s3 <= 6'd0;
                    cnt <= 6'd0;
                end
                CHIEN: begin
                    if (hit) roots <= roots + 2'd1;
                    // Positions 62..12 arrive first; later hits land in parity and are not kept
                    if (cnt <= 6'd50) flip <= {flip[49:0], hit};
                    l1  <= mul_a(l1);
                    l2  <= mul_a2(l2);
                    cnt <= (cnt == 6'd62) ? 6'd0 : cnt + 6'd1;
                end
                SEND: begin
                    if (!valid_out) begin
                        uncorrectable <= unc_w;
                        err_cnt       <= unc_w ? 2'd0 : roots;
                        data_out_all  <= msg_w;
                        out_sr        <= msg_w;
                        out_idx       <= 6'd0;
                        valid_out     <= 1'b1;
                    end else if (ready_out) begin
                        out_sr <= {out_sr[49:0], 1'b0};
                        if (out_idx == 6'd50)
                            valid_out <= 1'b0;
                        else
                            out_idx <= out_idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_decoder.sv
// tb/tb_bch_decoder.sv - scoreboard bench for bch_decoder with generator-division reference
module tb_bch_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic        data_in;
    logic        valid_out;
    logic        ready_out;
    logic        data_out;
    logic        last_out;
    logic [50:0] data_out_all;
    logic [1:0]  err_cnt;
    logic        uncorrectable;

    bch_decoder dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .last_out(last_out), .data_out_all(data_out_all),
        .err_cnt(err_cnt), .uncorrectable(uncorrectable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [50:0] msg;
        logic [1:0]  err;
        logic        unc;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_accept = 0;
    bit          rand_ready = 0;
    logic [11:0] pw[63];

    localparam logic [11:0] G_LOW = 12'h539;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [62:0] encode(input logic [50:0] m);
        logic [11:0] r;
        logic        fb;
        r = 12'd0;
        for (int i = 50; i >= 0; i--) begin
            fb = m[i] ^ r[11];
            r  = {r[10:0], 1'b0} ^ (fb ? G_LOW : 12'd0);
        end
        return {m, r};
    endfunction

    function automatic logic [11:0] rem63(input logic [62:0] w);
        logic [11:0] r;
        logic        fb;
        r = 12'd0;
        for (int i = 62; i >= 0; i--) begin
            fb = r[11];
            r  = {r[10:0], w[i]} ^ (fb ? G_LOW : 12'd0);
        end
        return r;
    endfunction

    // Bounded-distance reference: find an error pattern of weight <= 2 whose remainder matches
    task automatic ref_decode(input logic [62:0] w, output exp_t e);
        logic [11:0] r;
        logic [62:0] epat;
        bit          found;
        r     = rem63(w);
        found = 0;
        epat  = 63'd0;
        e.err = 2'd0;
        if (r == 12'd0) begin
            found = 1;
        end
        for (int i = 0; i < 63 && !found; i++) begin
            if (pw[i] == r) begin
                found = 1; epat = 63'd1 << i; e.err = 2'd1;
            end
        end
        for (int i = 0; i < 63 && !found; i++) begin
            for (int j = i + 1; j < 63 && !found; j++) begin
                if ((pw[i] ^ pw[j]) == r) begin
                    found = 1; epat = (63'd1 << i) | (63'd1 << j); e.err = 2'd2;
                end
            end
        end
        e.unc = !found;
        if (!found) e.err = 2'd0;
        epat  = w ^ epat;
        e.msg = epat[62:12];
    endtask

    task automatic push_exp(input logic [50:0] m, input logic [1:0] err, input logic unc);
        exp_t e;
        e.msg = m; e.err = err; e.unc = unc;
        sbq.push_back(e);
    endtask

    task automatic send_word(input logic [62:0] cw, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int t = 0;
            while (!ready_in && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!ready_in) begin
                check("ready_in_timeout", 64'(ready_in), 64'd1);
                valid_in = 1'b0;
                return;
            end
            valid_in    = 1'b1;
            data_in     = cw[62-i];
            last_accept = cyc + 1;
            @(negedge clk);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_out = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    int   bidx = 0;
    logic prev_stall = 1'b0;
    logic prev_d = 1'b0;
    logic prev_vo = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bidx = 0; prev_stall = 1'b0; prev_vo = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_data", 64'(data_out), 64'(prev_d));
            end
            if (valid_out && !prev_vo)
                check("latency", 64'(cyc - last_accept), 64'd65);
            if (valid_out && ready_out) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    if (bidx == 0) begin
                        check("data_out_all", 64'(data_out_all), 64'(sbq[0].msg));
                        check("err_cnt", 64'(err_cnt), 64'(sbq[0].err));
                        check("uncorrectable", 64'(uncorrectable), 64'(sbq[0].unc));
                    end
                    check("data_out", 64'(data_out), 64'(sbq[0].msg[50-bidx]));
                    check("last_out", 64'(last_out), 64'(bidx == 50));
                    if (bidx == 50) begin
                        void'(sbq.pop_front());
                        bidx = 0;
                    end else begin
                        bidx++;
                    end
                end
            end
            prev_stall = valid_out && !ready_out;
            prev_d     = data_out;
            prev_vo    = valid_out;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready_in"}, 64'(ready_in), 64'd1);
        check({tag, "_valid_out"}, 64'(valid_out), 64'd0);
        check({tag, "_last_out"}, 64'(last_out), 64'd0);
        check({tag, "_data_out"}, 64'(data_out), 64'd0);
        check({tag, "_data_out_all"}, 64'(data_out_all), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        check({tag, "_unc"}, 64'(uncorrectable), 64'd0);
    endtask

    initial begin
        logic [50:0] m;
        logic [62:0] cw;
        exp_t        e;
        int          p1, p2, p3, t;

        for (int i = 0; i < 63; i++) pw[i] = rem63(63'd1 << i);

        rst = 1'b1; valid_in = 1'b0; data_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        push_exp(51'd0, 2'd0, 1'b0);
        send_word(63'd0, 63);

        push_exp({51{1'b1}}, 2'd0, 1'b0);
        send_word({63{1'b1}}, 63);

        for (int p = 0; p < 63; p++) begin
            push_exp(51'd0, 2'd1, 1'b0);
            send_word(63'd1 << p, 63);
        end

        push_exp({51{1'b1}}, 2'd2, 1'b0);
        send_word({63{1'b1}} ^ (63'd1 << 62) ^ 63'd1, 63);

        for (int k = 0; k < 10; k++) begin
            m  = 51'({$urandom(), $urandom()});
            cw = encode(m);
            p1 = $urandom_range(62, 0);
            p2 = (p1 + 1 + $urandom_range(61, 0)) % 63;
            push_exp(m, 2'd2, 1'b0);
            send_word(cw ^ (63'd1 << p1) ^ (63'd1 << p2), 63);
            if (k == 3) begin
                repeat (10) @(negedge clk);
                valid_in = 1'b1; data_in = 1'b1;
                for (int q = 0; q < 5; q++) begin
                    check("ready_in_chien", 64'(ready_in), 64'd0);
                    @(negedge clk);
                end
                valid_in = 1'b0;
            end
        end

        rand_ready = 1;
        for (int k = 0; k < 10; k++) begin
            m  = 51'({$urandom(), $urandom()});
            cw = encode(m);
            p1 = $urandom_range(62, 0);
            p2 = (p1 + 1 + $urandom_range(60, 0)) % 63;
            p3 = p1;
            while (p3 == p1 || p3 == p2) p3 = $urandom_range(62, 0);
            cw = cw ^ (63'd1 << p1) ^ (63'd1 << p2) ^ (63'd1 << p3);
            ref_decode(cw, e);
            sbq.push_back(e);
            send_word(cw, 63);
        end
        rand_ready = 0;

        m  = 51'({$urandom(), $urandom()});
        send_word(encode(m) ^ 63'h5, 30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        m  = 51'({$urandom(), $urandom()});
        push_exp(m, 2'd1, 1'b0);
        send_word(encode(m) ^ (63'd1 << 40), 63);

        t = 0;
        while (sbq.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_scoreboard", 64'(sbq.size()), 64'd0);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bch_decoder.md
Name: bch_decoder

Overview:
Serial-in/serial-out BCH(63,51), t=2 decoder. It is the receive-side counterpart of the team's bch_encoder. It accepts one 63-bit codeword bit per handshake and computes the syndromes S1 and S3 over GF(64). It then runs a 63-step Chien search to correct up to 2 bit errors and emits the 51 corrected message bits serially and as a parallel word, with error status.

Parameters:
none (code fixed: N=63, K=51, t=2, GF(64) primitive poly p(x)=x^6+x+1, alpha=000010, g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset; one clock, synchronous active-high reset (fixed)
valid_in  input  1  data_in valid
ready_in  output  1  decoder accepts a bit; high only in RECV
data_in  input  1  received codeword bit
valid_out  output  1  data_out valid
ready_out  input  1  downstream ready
data_out  output  1  corrected message bit
last_out  output  1  high with the 51st message bit
data_out_all  output  51  corrected message, first-sent bit in [50]; stable during SEND
err_cnt  output  2  bits corrected (0/1/2); valid during SEND
uncorrectable  output  1  decode failure; valid during SEND

Behaviour:
- Bit order: first received bit is r62 (message MSB); bits 62..12 are message; bits 11..0 are parity, g-remainder MSB first. This matches the encoder output order.
- Transfer rules:
  - Input transfer when valid_in && ready_in.
  - Output transfer when valid_out && ready_out.
  - valid_out never depends on ready_out.
- Reset:
  - state=RECV, bit counter=0, S1=S3=0.
  - valid_out=0, last_out=0, data_out=0, data_out_all=0, err_cnt=0, uncorrectable=0.
  - Buffer contents don't care.
- States: RECV -> CALC -> CHIEN -> SEND -> RECV.
- RECV:
  - ready_in=1.
  - Per accepted bit r: buf <= {buf[61:0], r}; S1 <= S1*alpha ^ r; S3 <= S3*alpha^3 ^ r; cnt++.
  - After the 63rd accept (cnt==62 on transfer): go to CALC, cnt=0, ready_in drops the next cycle.
- CALC (1 cycle):
  - L0=S1; L1=S1^2*alpha; L2=(S3^S1^3)*alpha^2 (inversion-free locator S1+S1^2x+(S3+S1^3)x^2, pre-stepped to x=alpha^-62).
  - exp_deg = 0 if S1=S3=0; else 1 if S1!=0 and S3==S1^3; else 2 if S1!=0; else mark fail (S1=0, S3!=0).
- CHIEN (exactly 63 cycles, j=62 down to 0):
  - If exp_deg!=0 and L0^L1^L2==0, flip buf bit of position j and increment roots.
  - Each step: L1 *= alpha; L2 *= alpha^2.
  - Runs even with zero errors, giving fixed latency.
- End of CHIEN:
  - uncorrectable = fail || (roots != exp_deg).
  - err_cnt = uncorrectable ? 0 : roots.
  - If uncorrectable, the original received bits are output (flips undone; keep an unflipped copy or a flip mask).
  - data_out_all = message bits.
- SEND:
  - valid_out=1, data_out = current message bit (r62 first).
  - Advance on each transfer.
  - last_out with the 51st bit; after its transfer, valid_out=0 and state returns to RECV.
  - Outputs hold while ready_out=0.
- Latency: the first valid_out rises 65 cycles after the clock edge that accepted the 63rd input bit (CALC 1 + CHIEN 63 + register 1).
- GF multiplies are constant-multiplier XOR networks; S1^3 and S3^S1^3 use one general GF(64) multiplier instance in CALC.
- Back-to-back: no input is accepted during CALC/CHIEN/SEND. A new codeword can start the cycle after the last output transfer.
- rst mid-operation (any state) aborts at once; the partial codeword is discarded with no output.
- valid_in during non-RECV states is ignored.

Test Plan:
- All-zero codeword (63 zeros), ready_out=1 -> 51 zero bits out, data_out_all=0, err_cnt=0, uncorrectable=0, first valid_out exactly 65 cycles after last accept.
- All-ones codeword (63 ones, a valid codeword) -> data_out_all=51'h7_FFFF_FFFF_FFFF, err_cnt=0.
- All-zero codeword with the first received bit flipped -> data_out_all=0, err_cnt=1, uncorrectable=0; repeat for each single position 0..62 with the same result.
- All-ones codeword with the first and last received bits flipped -> data_out_all all ones, err_cnt=2; sweep random error pairs on random bch_encoder-generated words -> exact message recovered every time.
- Three random errors on encoder words -> output matches the golden model: either uncorrectable=1 with raw bits out, or the model's miscorrection. ready_out toggled randomly during SEND -> no bit lost or duplicated, last_out only on the 51st transfer.
- rst asserted after 30 input bits, then a full valid codeword -> only the second word is output, status from the second word alone; valid_in pulsed during CHIEN -> ready_in=0, no effect.
